nco_hop_sched: RTL

Sequencing controller for the dual-output NCO, which has a phase-increment input, a frequency-modulation input, a clock enable and a valid output.
- Holds a small table of phase-increment words and steps the NCO through them.
- Each hop lasts a programmable dwell, counted in enabled cycles.
- Flushes and warms the NCO pipeline before declaring samples valid.
- Sits between the host/config bus and the NCO instance in the BPSK transmit path.

---
 rtl/nco_pkg.sv | 23 ++
 rtl/nco_hop_sched_if.sv | 16 +
 rtl/nco_hop_table.sv | 32 +++
 rtl/nco_hop_sched.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// Shared definitions for the NCO hop scheduler.
//   state_e    : scheduler states
//   *_DEF      : default widths / NCO pipeline latency
//   eff_dwell  : effective dwell length (a programmed 0 behaves as 1)
package nco_pkg;

    localparam int APR_DEF    = 30;
    localparam int APRF_DEF   = 30;
    localparam int WARMUP_DEF = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_WARM,
        ST_RUN,
        ST_DONE
    } state_e;

    function automatic int unsigned eff_dwell(input int unsigned dwell);
        return (dwell == 0) ? 1 : dwell;
    endfunction

endpackage

// File: rtl/nco_hop_sched_if.sv
// Host/config bus into the hop table.
//   cfg_we   : write strobe
//   cfg_addr : hop-table entry
//   cfg_data : phase-increment word
// master = host side, slave = scheduler side.
interface nco_hop_sched_if #(
    parameter int AW  = 3,
    parameter int APR = 30
);
    logic           cfg_we;
    logic [AW-1:0]  cfg_addr;
    logic [APR-1:0] cfg_data;

    modport master (output cfg_we, cfg_addr, cfg_data);
    modport slave  (input  cfg_we, cfg_addr, cfg_data);
endinterface

// File: rtl/nco_hop_table.sv
// NHOP x APR phase-increment register file.
//   we/waddr/wdata : synchronous write port
//   re/raddr/rdata : registered read port; rdata holds between reads
// A read and a write to the same entry in one cycle returns the old word.
module nco_hop_table #(
    parameter int NHOP = 8,
    parameter int AW   = 3,
    parameter int APR  = 30
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  logic [APR-1:0] wdata,
    input  logic           re,
    input  logic [AW-1:0]  raddr,
    output logic [APR-1:0] rdata
);

    logic [NHOP-1:0][APR-1:0] mem;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem   <= '0;
            rdata <= '0;
        end else begin
            if (we) mem[waddr] <= wdata;
            if (re) rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/nco_hop_sched.sv
// Frequency-hop sequencer for the dual-output NCO.
//   clk, reset_n       : clock, synchronous active-low reset
//   cfg                : hop-table write bus (slave)
//   nhop_i, dwell_i    : last hop index (sampled at start), dwell per hop
//   fm_i               : FM offset, sampled at start
//   start_i, stop_i    : single-cycle requests
//   nco_valid_i        : NCO out_valid
//   phi_inc_o, freq_mod_o, nco_clken_o, nco_reset_n_o : NCO controls
//   hop_idx_o, hop_strobe_o, sample_valid_o, busy_o, done_o : status
// Build option NCO_HOP_LOOP_EN: wrap to hop 0 after the last hop and run
// until stop_i instead of finishing.
module nco_hop_sched
    import nco_pkg::*;
#(
    parameter int APR    = APR_DEF,
    parameter int APRF   = APRF_DEF,
    parameter int NHOP   = 8,
    parameter int AW     = 3,
    parameter int DWW    = 16,
    parameter int WARMUP = WARMUP_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    nco_hop_sched_if.slave   cfg,
    input  logic [AW-1:0]    nhop_i,
    input  logic [DWW-1:0]   dwell_i,
    input  logic [APRF-1:0]  fm_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             nco_valid_i,
    output logic [APR-1:0]   phi_inc_o,
    output logic [APRF-1:0]  freq_mod_o,
    output logic             nco_clken_o,
    output logic             nco_reset_n_o,
    output logic [AW-1:0]    hop_idx_o,
    output logic             hop_strobe_o,
    output logic             sample_valid_o,
    output logic             busy_o,
    output logic             done_o
);

    // Warm-up watchdog: leave WARM after WTO enabled cycles even without valid.
    localparam int WTO = WARMUP + 4;
    localparam int WCW = $clog2(WTO + 1);

    state_e          state, state_nx;
    logic [AW-1:0]   nhop_q, ld_addr;
    logic [DWW-1:0]  dwell_q, dwell_cnt;
    logic [WCW-1:0]  warm_cnt;
    logic            ld_en, adv, warm_done, hop_end, last_hop;

    // phi_inc_o is the table's read register: it only changes on a load.
    nco_hop_table #(.NHOP(NHOP), .AW(AW), .APR(APR)) u_tbl (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (cfg.cfg_we),
        .waddr   (cfg.cfg_addr),
        .wdata   (cfg.cfg_data),
        .re      (ld_en),
        .raddr   (ld_addr),
        .rdata   (phi_inc_o)
    );

    assign sample_valid_o = (state == ST_RUN) && nco_valid_i;

    always_comb begin
        state_nx  = state;
        ld_en     = 1'b0;
        ld_addr   = hop_idx_o;
        adv       = 1'b0;
        warm_done = nco_valid_i || (warm_cnt == WCW'(WTO - 1));
        hop_end   = dwell_cnt >= (dwell_q - DWW'(1));
        last_hop  = hop_idx_o >= nhop_q;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_nx = ST_FLUSH;
                    ld_en    = 1'b1;
                    ld_addr  = '0;
                end
            end
            ST_FLUSH: state_nx = ST_WARM;
            ST_WARM: begin
                if (stop_i)         state_nx = ST_DONE;
                else if (warm_done) state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_nx = ST_DONE;
                end else if (hop_end) begin
                    if (!last_hop) begin
                        adv     = 1'b1;
                        ld_en   = 1'b1;
                        ld_addr = hop_idx_o + AW'(1);
                    end else begin
`ifdef NCO_HOP_LOOP_EN
                        adv     = 1'b1;
                        ld_en   = 1'b1;
                        ld_addr = '0;
`else
                        state_nx = ST_DONE;
`endif
                    end
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            freq_mod_o    <= '0;
            nco_clken_o   <= 1'b0;
            nco_reset_n_o <= 1'b0;
            hop_idx_o     <= '0;
            hop_strobe_o  <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            nhop_q        <= '0;
            dwell_q       <= '0;
            dwell_cnt     <= '0;
            warm_cnt      <= '0;
        end else begin
            state         <= state_nx;
            // Control outputs are registered off the next state.
            nco_reset_n_o <= (state_nx != ST_FLUSH);
            nco_clken_o   <= (state_nx == ST_WARM) || (state_nx == ST_RUN);
            busy_o        <= (state_nx != ST_IDLE);
            done_o        <= (state_nx == ST_DONE);
            hop_strobe_o  <= adv;

            if (state == ST_IDLE && start_i) begin
                freq_mod_o <= fm_i;
                nhop_q     <= nhop_i;
                hop_idx_o  <= '0;
            end
            if (adv) hop_idx_o <= ld_addr;

            if (state == ST_FLUSH)
                warm_cnt <= '0;
            else if (state == ST_WARM && warm_cnt != '1)
                warm_cnt <= warm_cnt + WCW'(1);

            // Outside RUN (and on every hop) keep re-sampling dwell so the
            // value at the hop boundary governs the coming hop.
            if (state != ST_RUN || adv) begin
                dwell_cnt <= '0;
                dwell_q   <= DWW'(eff_dwell(32'(dwell_i)));
            end else if (dwell_cnt != '1) begin
                dwell_cnt <= dwell_cnt + DWW'(1);
            end
        end
    end

endmodule
